alu_mul_sequencer: RTL

Multi-cycle RV32M MUL unit with no multiplier of its own. It computes the low DATA_WIDTH bits of A*B by driving the shared ALU through an iterative shift-add sequence, issuing one ALU operation per cycle. It sits beside the execute-stage ALU; the execute-stage mux hands it the ALU operand/opcode inputs while busy=1, and the pipeline stalls until done.

---
 rtl/alu_mul_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
//   Multi-cycle MUL (low DATA_WIDTH bits of op_a*op_b) built without a
//   multiplier. It borrows the execute-stage ALU and runs a shift-add loop,
//   issuing one ALU operation per cycle: ADD (acc += a), SLL (a <<= 1),
//   SRL (b >>= 1).
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-low reset
//   start             request pulse, only looked at in IDLE
//   op_a, op_b        multiplicand / multiplier, latched on accepted start
//   alu_op            opcode to the shared ALU (0 when not sequencing)
//   alu_src_a/_b      ALU operands (0 when not sequencing)
//   alu_result        combinational ALU result, consumed in the same cycle
//   busy              high in every state but IDLE
//   done              one-cycle pulse in DONE
//   product           result, held until the next DONE
//
// Build option
//   MUL_SEQ_EARLY_EXIT_EN : when defined, op_b==0 jumps straight to DONE and
//   the loop stops as soon as the shifted multiplier becomes zero. When
//   undefined, every job runs exactly DATA_WIDTH iterations.
module alu_mul_sequencer #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DATA_WIDTH-1:0]    op_a,
    input  logic [DATA_WIDTH-1:0]    op_b,
    output logic [OPCODE_LENGTH-1:0] alu_op,
    output logic [DATA_WIDTH-1:0]    alu_src_a,
    output logic [DATA_WIDTH-1:0]    alu_src_b,
    input  logic [DATA_WIDTH-1:0]    alu_result,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    product
);

    localparam int IW = $clog2(DATA_WIDTH);
    localparam logic [IW-1:0] LAST_ITER = IW'(DATA_WIDTH - 1);

    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b0011);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4'b0100);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHL,
        S_SHR,
        S_DONE
    } state_t;

    state_t                state, next_state;
    logic [DATA_WIDTH-1:0] acc, a_reg, b_reg;
    logic [IW-1:0]         iter;
    logic                  loop_exit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            acc     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            iter    <= '0;
            product <= '0;
        end else begin
            state <= next_state;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg <= op_a;
                        b_reg <= op_b;
                        acc   <= '0;
                        iter  <= '0;
                    end
                end
                S_ADD: acc   <= alu_result;
                S_SHL: a_reg <= alu_result;
                S_SHR: begin
                    b_reg <= alu_result;
                    // Saturate: the last iteration exits, so no wrap is needed.
                    if (iter != LAST_ITER)
                        iter <= iter + IW'(1);
                end
                S_DONE: product <= acc;
                default: ;
            endcase
        end
    end

    // Loop termination after the multiplier shift.
`ifdef MUL_SEQ_EARLY_EXIT_EN
    assign loop_exit = (alu_result == '0) || (iter == LAST_ITER);
`else
    assign loop_exit = (iter == LAST_ITER);
`endif

    always_comb begin
        next_state = state;
        alu_op     = '0;
        alu_src_a  = '0;
        alu_src_b  = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
`ifdef MUL_SEQ_EARLY_EXIT_EN
                    if (op_b == '0)
                        next_state = S_DONE;
                    else
`endif
                    next_state = op_b[0] ? S_ADD : S_SHL;
                end
            end
            S_ADD: begin
                alu_op     = OP_ADD;
                alu_src_a  = acc;
                alu_src_b  = a_reg;
                next_state = S_SHL;
            end
            S_SHL: begin
                alu_op     = OP_SLL;
                alu_src_a  = a_reg;
                alu_src_b  = DATA_WIDTH'(1);
                next_state = S_SHR;
            end
            S_SHR: begin
                alu_op    = OP_SRL;
                alu_src_a = b_reg;
                alu_src_b = DATA_WIDTH'(1);
                // alu_result is the new multiplier; its LSB picks the next step.
                if (loop_exit)
                    next_state = S_DONE;
                else
                    next_state = alu_result[0] ? S_ADD : S_SHL;
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule
